// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records each round's LED display,
// detects its end by a silence gap, then replays it as timed button presses.
module jogador_automatico #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned JOGAR_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 2000,
  parameter int unsigned PRESS_CYCLES   = 2,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       venceu,
  output logic       falhou,
  output logic       erro,
  output logic [2:0] db_estado,
  output logic [4:0] db_tamanho,
  output logic [3:0] db_indice
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'b000,
    INICIA    = 3'b001,
    OBSERVA   = 3'b010,
    PRESSIONA = 3'b011,
    SOLTA     = 3'b100,
    FIM       = 3'b101,
    ERRO      = 3'b110
  } estado_t;

  estado_t       state, state_n;
  logic [3:0]    mem [DEPTH];
  logic [3:0]    leds_ant;
  logic [GW-1:0] gap, gap_n;
  logic [7:0]    fase, fase_n;
  logic [4:0]    tam_n;
  logic [3:0]    idx_n;
  logic          venceu_n, falhou_n, erro_n, captura;
  logic          onehot, subida;

  assign onehot    = (leds & (leds - 4'd1)) == 4'd0;
  assign subida    = (leds != 4'd0) && (leds_ant == 4'd0);
  assign db_estado = state;

  always_comb begin
    state_n  = state;
    tam_n    = db_tamanho;
    idx_n    = db_indice;
    gap_n    = gap;
    fase_n   = fase;
    venceu_n = venceu;
    falhou_n = falhou;
    erro_n   = erro;
    captura  = 1'b0;
    case (state)
      OCIOSO, FIM: begin
        if (iniciar) begin
          state_n  = INICIA;
          venceu_n = 1'b0;
          falhou_n = 1'b0;
          erro_n   = 1'b0;
          tam_n    = '0;
          idx_n    = '0;
          gap_n    = '0;
          fase_n   = '0;
        end
      end
      INICIA: begin
        if (fase == 8'(JOGAR_CYCLES - 1)) begin
          state_n = OBSERVA;
          fase_n  = '0;
        end else begin
          fase_n = fase + 8'd1;
        end
      end
      OBSERVA: begin
        if (leds != 4'd0) begin
          gap_n = '0;
        end else if (db_tamanho != 5'd0) begin
          if (gap == GW'(GAP_CYCLES)) begin
            state_n = PRESSIONA;
            idx_n   = '0;
            gap_n   = '0;
            fase_n  = '0;
          end else begin
            gap_n = gap + GW'(1);
          end
        end
        if (!onehot) begin
          state_n = ERRO;
          erro_n  = 1'b1;
        end else if (subida) begin
          if (db_tamanho == 5'(DEPTH)) begin
            state_n = ERRO;
            erro_n  = 1'b1;
          end else begin
            captura = 1'b1;
            tam_n   = db_tamanho + 5'd1;
          end
        end
      end
      PRESSIONA: begin
        if (fase == 8'(PRESS_CYCLES - 1)) begin
          state_n = SOLTA;
          fase_n  = '0;
        end else begin
          fase_n = fase + 8'd1;
        end
      end
      SOLTA: begin
        if (fase == 8'(RELEASE_CYCLES - 1)) begin
          fase_n = '0;
          if ({1'b0, db_indice} == db_tamanho - 5'd1) begin
            state_n = OBSERVA;
            tam_n   = '0;
            gap_n   = '0;
          end else begin
            state_n = PRESSIONA;
            idx_n   = db_indice + 4'd1;
          end
        end else begin
          fase_n = fase + 8'd1;
        end
      end
      default: ;
    endcase
    // Game outcome overrides whatever the state logic above decided.
    if ((state inside {INICIA, OBSERVA, PRESSIONA, SOLTA}) && (ganhou || perdeu)) begin
      state_n  = FIM;
      venceu_n = venceu | ganhou;
      falhou_n = falhou | perdeu;
      erro_n   = erro;
      captura  = 1'b0;
      tam_n    = db_tamanho;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= OCIOSO;
      jogar      <= 1'b0;
      botoes     <= '0;
      ativo      <= 1'b0;
      venceu     <= 1'b0;
      falhou     <= 1'b0;
      erro       <= 1'b0;
      db_tamanho <= '0;
      db_indice  <= '0;
      gap        <= '0;
      fase       <= '0;
      leds_ant   <= '0;
    end else begin
      state      <= state_n;
      jogar      <= (state_n == INICIA);
      botoes     <= (state_n == PRESSIONA) ? mem[idx_n] : 4'd0;
      ativo      <= !(state_n inside {OCIOSO, FIM, ERRO});
      venceu     <= venceu_n;
      falhou     <= falhou_n;
      erro       <= erro_n;
      db_tamanho <= tam_n;
      db_indice  <= idx_n;
      gap        <= gap_n;
      fase       <= fase_n;
      leds_ant   <= leds;
    end
  end

  always_ff @(posedge clock) begin
    if (captura) mem[db_tamanho[3:0]] <= leds;
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: directed game rounds, with a scoreboard of expected presses.
module tb_jogador_automatico;
  localparam int GAP = 2000;

  logic       clock = 1'b0;
  logic       reset, iniciar, ganhou, perdeu, echo;
  logic [3:0] leds, leds_show, botoes;
  logic       jogar, ativo, venceu, falhou, erro;
  logic [2:0] db_estado;
  logic [4:0] db_tamanho;
  logic [3:0] db_indice;

  always #5 clock = ~clock;

  // Game model echoes the pressed button onto its LEDs, which the player must ignore.
  assign leds = leds_show | (echo ? botoes : 4'b0000);

  jogador_automatico #(
    .DEPTH(16), .JOGAR_CYCLES(2), .GAP_CYCLES(GAP), .PRESS_CYCLES(2), .RELEASE_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .jogar(jogar), .botoes(botoes),
    .ativo(ativo), .venceu(venceu), .falhou(falhou), .erro(erro),
    .db_estado(db_estado), .db_tamanho(db_tamanho), .db_indice(db_indice)
  );

  int         total = 0, bad = 0, presses = 0;
  bit         chk_len = 1'b1;
  logic [3:0] exp_q[$];
  logic [3:0] seq[4];

  task automatic chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each new press and checks press/release/jogar lengths.
  logic [3:0] prev_b = 4'd0;
  logic       prev_j = 1'b0;
  int         blen = 0, jlen = 0, zc = 1000;
  always @(negedge clock) begin
    if (botoes != 4'd0 && prev_b == 4'd0) begin
      if (zc < 100) chk("release_len", zc, 2);
      if (exp_q.size() == 0) chk("unexpected_press", int'(botoes), 0);
      else chk("press_value", int'(botoes), int'(exp_q.pop_front()));
      blen = 0;
    end
    if (botoes != 4'd0) blen++;
    if (botoes == 4'd0 && prev_b != 4'd0) begin
      if (chk_len) chk("press_len", blen, 2);
      presses++;
      zc = 0;
    end
    if (botoes == 4'd0 && zc < 1000) zc++;
    if (jogar) jlen++;
    if (!jogar && prev_j) begin
      chk("jogar_len", jlen, 2);
      jlen = 0;
    end
    prev_b = botoes;
    prev_j = jogar;
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic start();
    @(posedge clock); #1 iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    @(negedge clock);
    chk("start_jogar1", int'(jogar), 1);
    chk("start_state", int'(db_estado), 1);
    chk("start_ativo", int'(ativo), 1);
    @(negedge clock);
    chk("start_jogar2", int'(jogar), 1);
    @(negedge clock);
    chk("start_jogar_end", int'(jogar), 0);
    chk("start_observa", int'(db_estado), 2);
  endtask

  task automatic show(int n);
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      leds_show = seq[i];
      repeat (3) @(posedge clock);
      #1 leds_show = 4'd0;
      if (i != n - 1) begin
        repeat (2) @(posedge clock);
        #1;
      end
    end
  endtask

  // Called right after the last LED falls; counts edges to the first press.
  task automatic measure_gap(int r);
    int k = 0;
    do begin
      @(posedge clock); k++;
      @(negedge clock);
      if (k == 1) chk("tamanho_recorded", int'(db_tamanho), r);
    end while (botoes == 4'd0 && k < GAP + 50);
    chk("gap_latency", k, GAP + 1);
  endtask

  task automatic wait_presses(int target);
    for (int i = 0; i < 200 && presses < target; i++) @(negedge clock);
    chk("press_count", presses, target);
  endtask

  task automatic wait_state(int code, int budget, string name);
    for (int i = 0; i < budget && int'(db_estado) != code; i++) @(negedge clock);
    chk(name, int'(db_estado), code);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
    leds_show = 4'd0; echo = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_state", int'(db_estado), 0);
      chk("idle_botoes", int'(botoes), 0);
      chk("idle_jogar", int'(jogar), 0);
    end
    chk("rst_ativo", int'(ativo), 0);
    chk("rst_flags", int'({venceu, falhou, erro}), 0);
    chk("rst_tamanho", int'(db_tamanho), 0);
    chk("rst_indice", int'(db_indice), 0);

    // Three growing rounds, then the game declares a win.
    echo = 1'b1;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    start();
    for (int r = 1; r <= 3; r++) begin
      int base = presses;
      for (int i = 0; i < r; i++) exp_q.push_back(seq[i]);
      show(r);
      measure_gap(r);
      wait_presses(base + r);
      wait_state(2, 20, "back_to_observa");
      chk("tamanho_cleared", int'(db_tamanho), 0);
    end
    @(posedge clock); #1 ganhou = 1'b1;
    @(posedge clock); #1 ganhou = 1'b0;
    @(negedge clock);
    chk("win_state", int'(db_estado), 5);
    chk("win_venceu", int'(venceu), 1);
    chk("win_falhou", int'(falhou), 0);
    chk("win_botoes", int'(botoes), 0);
    chk("win_ativo", int'(ativo), 0);

    // Loss during a press cuts it short.
    seq[0] = 4'b0010;
    start();
    chk("restart_venceu_clr", int'(venceu), 0);
    exp_q.push_back(seq[0]);
    show(1);
    measure_gap(1);
    chk_len = 1'b0;
    perdeu = 1'b1;
    @(posedge clock); #1 perdeu = 1'b0;
    @(negedge clock);
    chk("loss_state", int'(db_estado), 5);
    chk("loss_falhou", int'(falhou), 1);
    chk("loss_venceu", int'(venceu), 0);
    chk("loss_botoes", int'(botoes), 0);
    repeat (3) @(negedge clock);
    chk_len = 1'b1;

    // Non-one-hot LEDs lock the player in ERRO until reset.
    start();
    @(posedge clock); #1 leds_show = 4'b0011;
    @(posedge clock); #1 leds_show = 4'b0000;
    @(negedge clock);
    chk("err_state", int'(db_estado), 6);
    chk("err_flag", int'(erro), 1);
    chk("err_ativo", int'(ativo), 0);
    @(posedge clock); #1 iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    repeat (3) @(negedge clock);
    chk("err_sticky", int'(db_estado), 6);
    chk("err_no_jogar", int'(jogar), 0);
    do_reset();
    @(negedge clock);
    chk("err_reset_state", int'(db_estado), 0);
    chk("err_reset_flag", int'(erro), 0);

    // Seventeen pulses overflow the 16-entry record.
    start();
    for (int i = 0; i < 17; i++) begin
      logic [3:0] v;
      v = 4'b0001 << (i % 4);
      if (i == 16) begin
        @(negedge clock);
        chk("full_tamanho", int'(db_tamanho), 16);
        chk("full_state", int'(db_estado), 2);
      end
      @(posedge clock); #1 leds_show = v;
      @(posedge clock); #1 leds_show = 4'd0;
    end
    @(negedge clock);
    chk("ovf_state", int'(db_estado), 6);
    chk("ovf_erro", int'(erro), 1);
    do_reset();

    // Reset during SOLTA aborts everything on the next edge.
    seq[0] = 4'b0100;
    start();
    exp_q.push_back(seq[0]);
    show(1);
    wait_state(4, GAP + 50, "reach_solta");
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_state", int'(db_estado), 0);
    chk("abort_botoes", int'(botoes), 0);
    chk("abort_jogar", int'(jogar), 0);
    chk("abort_ativo", int'(ativo), 0);
    chk("abort_tamanho", int'(db_tamanho), 0);
    chk("abort_indice", int'(db_indice), 0);
    chk("abort_flags", int'({venceu, falhou, erro}), 0);

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jogador_automatico.md
# jogador_automatico

Automatic player for the memory challenge game: it drives the game's `jogar` and `botoes` inputs and reads its `leds`, `ganhou` and `perdeu` outputs. Each round it records the LED sequence the game displays, detects the end of the display by a silence gap, then replays the sequence as timed button presses. It is used for hardware self-test on the board and as a stimulus source in system benches, replacing the hand-written press tasks.

## Interface
- `DEPTH`, 16: maximum recorded sequence length (matches game memory).
- `JOGAR_CYCLES`, 2: cycles `jogar` is held high per start.
- `GAP_CYCLES`, 2000: consecutive cycles of `leds == 0` that end the display phase.
- `PRESS_CYCLES`, 2: cycles each button is held.
- `RELEASE_CYCLES`, 2: cycles of `botoes == 0` after each press.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  one-cycle start request; accepted only in OCIOSO or FIM.
- `leds`  in  4  game LED outputs; must be one-hot or zero.
- `ganhou`  in  1  game win flag.
- `perdeu`  in  1  game loss flag.
- `jogar`  out  4→1  start pulse to the game, 1 bit.
- `botoes`  out  4  one-hot button drive to the game.
- `ativo`  out  1  high in every state except OCIOSO, FIM, ERRO.
- `venceu`  out  1  latched: game reported `ganhou`.
- `falhou`  out  1  latched: game reported `perdeu`.
- `erro`  out  1  latched: protocol violation (non-one-hot LEDs or overflow).
- `db_estado`  out  3  current state code.
- `db_tamanho`  out  5  entries recorded this round (0..DEPTH).
- `db_indice`  out  4  current replay index.

## Operation
- States/codes: OCIOSO 000, INICIA 001, OBSERVA 010, PRESSIONA 011, SOLTA 100, FIM 101, ERRO 110.
- OCIOSO/FIM: `iniciar` → INICIA; clears `venceu`, `falhou`, `erro`, `db_tamanho`, `db_indice`, gap counter.
- INICIA: `jogar = 1` for exactly JOGAR_CYCLES cycles, then OBSERVA.
- OBSERVA: register `leds` each cycle as `leds_ant`. Capture when `leds != 0 && leds_ant == 0`: write `leds` to `mem[db_tamanho]`, increment `db_tamanho`. The gap counter resets on any nonzero `leds`. When `db_tamanho > 0` it counts cycles with `leds == 0`. At GAP_CYCLES → PRESSIONA with `db_indice = 0`. No counting while `db_tamanho == 0`.
- PRESSIONA: `botoes = mem[db_indice]` for PRESS_CYCLES, then SOLTA.
- SOLTA: `botoes = 0` for RELEASE_CYCLES. Then, if `db_indice == db_tamanho-1`, go to OBSERVA with `db_tamanho = 0`, counter cleared, and `leds_ant` reloaded from current `leds`. Else increment `db_indice` → PRESSIONA.
- LED echo during PRESSIONA/SOLTA is ignored (no capture).
- `ganhou` in any of INICIA/OBSERVA/PRESSIONA/SOLTA → FIM, set `venceu`. `perdeu` → FIM, set `falhou`. Both in the same cycle → FIM with both set. These checks have priority over every other transition.
- Errors, checked in OBSERVA only and below win/loss priority, both → ERRO with `erro = 1`:
  - `leds` neither zero nor one-hot.
  - Capture attempted with `db_tamanho == DEPTH`.
- ERRO leaves only on `reset`. `iniciar` is ignored in ERRO.
- `botoes = 0` and `jogar = 0` in every state not listed above as driving them.

## Timing
- Reset, synchronous: state OCIOSO; `jogar`, `botoes`, `ativo`, `venceu`, `falhou`, `erro` = 0; `db_estado` = 000; `db_tamanho`, `db_indice` = 0; counters and `leds_ant` = 0. Memory contents are don't-care.
- Reset mid-operation aborts immediately: outputs go to reset values on the next edge, with no partial press completion.
- `iniciar` sampled at edge T: `jogar` high from T+1 through T+JOGAR_CYCLES.
- Capture latency: LED rising edge seen at edge T → `db_tamanho` updated at T+1.
- Last LED falls at edge T → first PRESSIONA cycle at T+GAP_CYCLES+1.
- Each replayed entry occupies exactly PRESS_CYCLES+RELEASE_CYCLES cycles. Outputs are registered and glitch-free.
- An LED held high across many cycles is one capture. Two pulses of the same colour separated by at least one zero cycle are two captures.

## Test plan
- Reset then idle: 10 cycles with no `iniciar` → `db_estado = 000`, `botoes = 0`, `jogar = 0`.
- Single round with a behavioural game model showing 0001 → model receives `jogar` for 2 cycles, then `botoes = 0001` for 2 cycles starting GAP_CYCLES+1 after the LED falls; `db_tamanho` returns to 0.
- Three rounds with growing sequence 0001, 0010, 0100 → replays of 1, 2, 3 presses in order; model asserts `ganhou` → `venceu = 1`, FIM, `botoes = 0`.
- `perdeu` asserted mid-PRESSIONA → FIM next edge, `falhou = 1`, press cut short.
- `leds = 0011` in OBSERVA → ERRO, `erro = 1`; `iniciar` ignored; `reset` → OCIOSO.
- 17 LED pulses in one round with DEPTH = 16 → ERRO on the 17th rising edge. Separately, `reset` asserted during SOLTA → all outputs at reset values one edge later.
